// File: rtl/imm_enc.sv
// Immediate encoder: packs a sign-extended immediate into the I/S/B/U/J fields of an instruction
// template through a 2-stage valid/ready pipeline. Range checks gated by
// YSYX_23060251_IMM_RANGE_CHECK_EN.
module imm_enc #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [5:1]       imm_sel_i,
  input  logic [63:0]      imm_i,
  input  logic [31:0]      base_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      inst_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  logic        s1_valid_q, s1_valid_d;
  logic [5:1]  s1_sel_q;
  logic [63:0] s1_imm_q;
  logic [31:0] s1_base_q;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] inst_q;
  logic [31:0] enc_inst;
  logic        s2_adv, s1_load, s2_load;

  assign s2_adv     = !s2_valid_q | out_ready_i;
  assign in_ready_o = !s1_valid_q | s2_adv;
  assign s1_load    = in_valid_i & in_ready_o;
  assign s2_load    = s2_adv & s1_valid_q;

  assign s1_valid_d = in_ready_o ? in_valid_i : s1_valid_q;
  assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

  // Invalid selects leave the template untouched.
  always_comb begin
    enc_inst = s1_base_q;
    case (s1_sel_q)
      5'b00001: enc_inst[31:20] = s1_imm_q[11:0];
      5'b00010: begin
        enc_inst[31:25] = s1_imm_q[11:5];
        enc_inst[11:7]  = s1_imm_q[4:0];
      end
      5'b00100: begin
        enc_inst[31]    = s1_imm_q[12];
        enc_inst[7]     = s1_imm_q[11];
        enc_inst[30:25] = s1_imm_q[10:5];
        enc_inst[11:8]  = s1_imm_q[4:1];
      end
      5'b01000: enc_inst[31:12] = s1_imm_q[31:12];
      5'b10000: begin
        enc_inst[31]    = s1_imm_q[20];
        enc_inst[19:12] = s1_imm_q[19:12];
        enc_inst[20]    = s1_imm_q[11];
        enc_inst[30:21] = s1_imm_q[10:1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= '0;
      s1_imm_q   <= '0;
      s1_base_q  <= '0;
      s2_valid_q <= 1'b0;
      inst_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        s1_sel_q  <= imm_sel_i;
        s1_imm_q  <= imm_i;
        s1_base_q <= base_i;
      end
      if (s2_load) inst_q <= enc_inst;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign inst_o      = inst_q;

`ifdef YSYX_23060251_IMM_RANGE_CHECK_EN
  logic             sext11, sext12, sext20, sext31;
  logic             enc_err;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Upper bits must all equal the field's sign bit for the value to fit.
  assign sext11 = (&s1_imm_q[63:11]) | ~(|s1_imm_q[63:11]);
  assign sext12 = (&s1_imm_q[63:12]) | ~(|s1_imm_q[63:12]);
  assign sext20 = (&s1_imm_q[63:20]) | ~(|s1_imm_q[63:20]);
  assign sext31 = (&s1_imm_q[63:31]) | ~(|s1_imm_q[63:31]);

  always_comb begin
    enc_err = 1'b1;
    case (s1_sel_q)
      5'b00001, 5'b00010: enc_err = !sext11;
      5'b00100:           enc_err = !sext12 | s1_imm_q[0];
      5'b01000:           enc_err = !sext31 | (|s1_imm_q[11:0]);
      5'b10000:           enc_err = !sext20 | s1_imm_q[0];
      default:            enc_err = 1'b1;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && out_ready_i && err_q && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (s2_load) err_q <= enc_err;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^s1_imm_q[63:32];
  assign err_o         = 1'b0;
  assign err_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_imm_enc.sv
// Self-checking bench for imm_enc: directed vectors, a queue-based reference model checked every
// cycle, and literal expectations on the delivered stream.
module tb_imm_enc;

  localparam logic [5:1] SelI = 5'b00001;
  localparam logic [5:1] SelS = 5'b00010;
  localparam logic [5:1] SelB = 5'b00100;
  localparam logic [5:1] SelU = 5'b01000;
  localparam logic [5:1] SelJ = 5'b10000;
`ifdef YSYX_23060251_IMM_RANGE_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [5:1]  imm_sel;
  logic [63:0] imm_v;
  logic [31:0] base_v;
  logic        in_ready_o, out_valid_o, err_o;
  logic [31:0] inst_o;
  logic [15:0] err_cnt_o;
  logic        in_ready2, out_valid2, err2;
  logic [31:0] inst2;
  logic [1:0]  err_cnt2;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    int unsigned n;
  } exp_t;

  exp_t        q[$];
  logic [31:0] got_inst[$];
  logic        got_err[$];
  int          total = 0;
  int          bad = 0;
  int unsigned edge_cnt = 0;
  int unsigned m_cnt = 0;

  always #5 clk_i = ~clk_i;

  imm_enc u_dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_o),
    .imm_sel_i  (imm_sel),
    .imm_i      (imm_v),
    .base_i     (base_v),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready),
    .inst_o     (inst_o),
    .err_o      (err_o),
    .err_cnt_o  (err_cnt_o)
  );

  imm_enc #(.CNT_W(2)) u_dut2 (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready2),
    .imm_sel_i  (imm_sel),
    .imm_i      (imm_v),
    .base_i     (base_v),
    .out_valid_o(out_valid2),
    .out_ready_i(out_ready),
    .inst_o     (inst2),
    .err_o      (err2),
    .err_cnt_o  (err_cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: spec field table plus signed-range arithmetic.
  function automatic logic [32:0] model(input logic [5:1] sel, input logic [63:0] imm,
                                        input logic [31:0] base);
    logic [31:0] inst;
    logic        err;
    longint      s;
    longint      lim_u;
    inst  = base;
    s     = imm;
    lim_u = 64'sd2147483648;
    err   = 1'b0;
    case (sel)
      SelI: begin
        inst[31:20] = imm[11:0];
        err = (s < -2048) || (s > 2047);
      end
      SelS: begin
        inst[31:25] = imm[11:5];
        inst[11:7]  = imm[4:0];
        err = (s < -2048) || (s > 2047);
      end
      SelB: begin
        inst[31] = imm[12];
        inst[7]  = imm[11];
        inst[30:25] = imm[10:5];
        inst[11:8]  = imm[4:1];
        err = (s < -4096) || (s > 4095) || (s % 2 != 0);
      end
      SelU: begin
        inst[31:12] = imm[31:12];
        err = (s < -lim_u) || (s >= lim_u) || (s % 4096 != 0);
      end
      SelJ: begin
        inst[31] = imm[20];
        inst[19:12] = imm[19:12];
        inst[20] = imm[11];
        inst[30:21] = imm[10:1];
        err = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
      end
      default: err = 1'b1;
    endcase
    if (!ChkEn) err = 1'b0;
    return {err, inst};
  endfunction

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  always @(negedge clk_i) begin
    if (rst_n) begin
      logic [32:0] m;
      exp_t        e;
      chk("out_valid", out_valid_o, (q.size() > 0) && (edge_cnt >= q[0].n));
      chk("in_ready", in_ready_o, !((q.size() >= 2) && !out_ready));
      chk("err_cnt", err_cnt_o, (m_cnt > 65535) ? 65535 : m_cnt);
      chk("err_cnt_w2", err_cnt2, (m_cnt > 3) ? 3 : m_cnt);
      chk("w2_valid", out_valid2, out_valid_o);
      if (out_valid_o && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("inst", inst_o, e.inst);
        chk("err", err_o, e.err);
        chk("w2_inst", inst2, e.inst);
        chk("w2_err", err2, e.err);
        got_inst.push_back(inst_o);
        got_err.push_back(err_o);
        if (e.err) m_cnt++;
      end
      if (in_valid && in_ready_o) begin
        m = model(imm_sel, imm_v, base_v);
        e.inst = m[31:0];
        e.err  = m[32];
        e.n    = edge_cnt + 2;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [5:1] sel, input logic [63:0] imm, input logic [31:0] base);
    int k;
    in_valid = 1'b1;
    imm_sel  = sel;
    imm_v    = imm;
    base_v   = base;
    for (k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (in_ready_o) break;
    end
    chk("accept_timeout", 64'(k < 50), 64'd1);
    @(posedge clk_i);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    imm_sel = '0; imm_v = '0; base_v = '0;
    idle(2);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_inst", inst_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", err_cnt_o, 0);
    rst_n = 1'b1;
    idle(1);

    send(SelI, 64'hFFFF_FFFF_FFFF_FFFF, 32'h13);
    idle(3);
    send(SelB, -64'sd4, 32'h63);
    send(SelJ, 64'd8, 32'h6F);
    send(SelU, 64'h1234_5000, 32'h37);
    idle(4);

    send(SelI, 64'h800, 32'h13);
    send(SelB, 64'd3, 32'h63);
    send(5'b00011, 64'h0, 32'h13);
    idle(4);
    chk("cnt_after_errs", err_cnt_o, ChkEn ? 3 : 0);

    // Backpressure: two held, third waits until release.
    out_ready = 1'b0;
    send(SelS, 64'hFFFF_FFFF_FFFF_FFFF, 32'h23);
    send(SelU, 64'h1000, 32'h17);
    fork
      send(SelJ, -64'sd2, 32'h6F);
      begin
        @(negedge clk_i);
        chk("bp_in_ready", in_ready_o, 0);
        repeat (3) begin
          @(negedge clk_i);
          chk("bp_hold_inst", inst_o, 32'hFE00_0FA3);
        end
        @(posedge clk_i);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(5);

    // Reset with two results in flight.
    out_ready = 1'b0;
    send(SelI, 64'h5, 32'h13);
    send(SelI, 64'h801, 32'h13);
    #2;
    rst_n = 1'b0;
    q.delete();
    m_cnt = 0;
    #1;
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_ready", in_ready_o, 1);
    chk("mid_rst_cnt", err_cnt_o, 0);
    chk("mid_rst_cnt2", err_cnt2, 0);
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(4);
    chk("no_stale_out", got_inst.size(), 10);

    for (int i = 0; i < 5; i++) send(5'b00000, 64'h0, 32'hABCD_0000 + i);
    idle(5);
    chk("sat_cnt2", err_cnt2, ChkEn ? 3 : 0);
    chk("sat_cnt16", err_cnt_o, ChkEn ? 5 : 0);
    idle(3);
    chk("sat_cnt2_hold", err_cnt2, ChkEn ? 3 : 0);

    chk("lit_i", got_inst[0], 32'hFFF0_0013);
    chk("lit_i_err", got_err[0], 0);
    chk("lit_b", got_inst[1], 32'hFE00_0EE3);
    chk("lit_j", got_inst[2], 32'h0080_006F);
    chk("lit_u", got_inst[3], 32'h1234_5037);
    chk("lit_i_range", got_inst[4], 32'h8000_0013);
    chk("lit_i_range_err", got_err[4], ChkEn);
    chk("lit_b_align", got_inst[5], 32'h0000_0163);
    chk("lit_b_align_err", got_err[5], ChkEn);
    chk("lit_badsel", got_inst[6], 32'h0000_0013);
    chk("lit_badsel_err", got_err[6], ChkEn);
    chk("lit_bp_s", got_inst[7], 32'hFE00_0FA3);
    chk("lit_bp_u", got_inst[8], 32'h0000_1017);
    chk("lit_bp_j", got_inst[9], 32'hFFFF_F06F);
    chk("lit_sat_base", got_inst[12], 32'hABCD_0002);
    chk("delivered", got_inst.size(), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
